// File: rtl/mips_multicycle_ctrl_pkg.sv
// ============================================================================
// mips_mc_pkg : state encodings, opcode/funct and ALU-op constants
// Rev 1.0
// ============================================================================
`default_nettype none

package mips_mc_pkg;

  typedef enum logic [3:0] {
    ST_FETCH    = 4'd0,
    ST_DECODE   = 4'd1,
    ST_MEMADR   = 4'd2,
    ST_MEMRD    = 4'd3,
    ST_MEMWB    = 4'd4,
    ST_MEMWR    = 4'd5,
    ST_EXECUTE  = 4'd6,
    ST_ALUWB    = 4'd7,
    ST_BRANCH   = 4'd8,
    ST_ADDIEXEC = 4'd9,
    ST_ADDIWB   = 4'd10,
    ST_JUMP     = 4'd11,
    ST_BNE      = 4'd12
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [2:0] ALUC_ADD = 3'b010;
  localparam logic [2:0] ALUC_SUB = 3'b110;
  localparam logic [2:0] ALUC_AND = 3'b000;
  localparam logic [2:0] ALUC_OR  = 3'b001;
  localparam logic [2:0] ALUC_SLT = 3'b111;

endpackage

`default_nettype wire

// File: rtl/mips_multicycle_ctrl_if.sv
// ============================================================================
// mips_multicycle_ctrl_if : controller <-> datapath signal bundle
// Rev 1.0
// ============================================================================
`default_nettype none

interface mips_multicycle_ctrl_if #(
  parameter int ALUCTRL_W = 3
);
  logic [5:0]           op;
  logic [5:0]           funct;
  logic                 zero;
  logic                 mem_ready;
  logic                 pcen;
  logic                 irwrite;
  logic                 regwrite;
  logic                 memwrite;
  logic                 iord;
  logic                 alusrca;
  logic                 regdst;
  logic                 memtoreg;
  logic [1:0]           alusrcb;
  logic [1:0]           pcsrc;
  logic [ALUCTRL_W-1:0] alucontrol;
  logic                 illegal_op;
  logic                 mem_timeout;
  logic [3:0]           state_dbg;

  modport master (
    input  op, funct, zero, mem_ready,
    output pcen, irwrite, regwrite, memwrite, iord, alusrca, regdst, memtoreg,
           alusrcb, pcsrc, alucontrol, illegal_op, mem_timeout, state_dbg
  );

  modport slave (
    output op, funct, zero, mem_ready,
    input  pcen, irwrite, regwrite, memwrite, iord, alusrca, regdst, memtoreg,
           alusrcb, pcsrc, alucontrol, illegal_op, mem_timeout, state_dbg
  );
endinterface

`default_nettype wire

// File: rtl/mips_multicycle_ctrl_aludec.sv
// ============================================================================
// mc_aludec : combinational ALU decoder (aluop, funct -> alucontrol)
// Rev 1.0
// ============================================================================
`default_nettype none

import mips_mc_pkg::*;

module mc_aludec (
  input  logic [1:0] aluop,
  input  logic [5:0] funct,
  output logic [2:0] alucontrol
);

  always_comb begin
    alucontrol = ALUC_ADD;
    case (aluop)
      ALUOP_SUB:   alucontrol = ALUC_SUB;
      ALUOP_FUNCT: begin
        case (funct)
          FN_SUB:  alucontrol = ALUC_SUB;
          FN_AND:  alucontrol = ALUC_AND;
          FN_OR:   alucontrol = ALUC_OR;
          FN_SLT:  alucontrol = ALUC_SLT;
          default: alucontrol = ALUC_ADD;
        endcase
      end
      default:     alucontrol = ALUC_ADD;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/mips_multicycle_ctrl.sv
// ============================================================================
// mips_multicycle_ctrl : multicycle MIPS control FSM with mem-ready stall
// timeout and illegal-opcode detection. Optional BNE support: MC_BNE_EN.
// Rev 1.0
// ============================================================================
`default_nettype none

import mips_mc_pkg::*;

module mips_multicycle_ctrl #(
  parameter int ALUCTRL_W = 3,
  parameter int STALL_MAX = 15
) (
  input  logic                  clk,
  input  logic                  reset,
  mips_multicycle_ctrl_if.master bus
);

  localparam logic [7:0] STALL_LAST = 8'(STALL_MAX - 1);

  state_t     state_q, state_d;
  logic [7:0] stall_cnt_q, stall_cnt_d;
  logic       illegal_q, illegal_d;

  logic       waiting, timeout;
  logic       pcwrite, branch, branch_cond;
  logic       irwrite, regwrite, memwrite, iord, alusrca, regdst, memtoreg;
  logic [1:0] alusrcb, pcsrc, aluop;
  logic [2:0] aluc3;

  assign waiting = (state_q inside {ST_FETCH, ST_MEMRD, ST_MEMWR}) && !bus.mem_ready;
  assign timeout = waiting && (stall_cnt_q == STALL_LAST);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_FETCH;
      stall_cnt_q <= 8'd0;
      illegal_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      stall_cnt_q <= stall_cnt_d;
      illegal_q   <= illegal_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    illegal_d = 1'b0;
    case (state_q)
      // The FETCH cycle that reports an illegal opcode issues no fetch, so hold here.
      ST_FETCH:    if (!timeout && !illegal_q && bus.mem_ready) state_d = ST_DECODE;
      ST_DECODE: begin
        case (bus.op)
          OP_LW, OP_SW: state_d = ST_MEMADR;
          OP_RTYPE:     state_d = ST_EXECUTE;
          OP_BEQ:       state_d = ST_BRANCH;
          OP_ADDI:      state_d = ST_ADDIEXEC;
          OP_J:         state_d = ST_JUMP;
`ifdef MC_BNE_EN
          OP_BNE:       state_d = ST_BNE;
`endif
          default: begin
            state_d   = ST_FETCH;
            illegal_d = 1'b1;
          end
        endcase
      end
      ST_MEMADR: begin
        if (bus.op == OP_LW)      state_d = ST_MEMRD;
        else if (bus.op == OP_SW) state_d = ST_MEMWR;
        else                      state_d = ST_FETCH;
      end
      ST_MEMRD: begin
        if (timeout)            state_d = ST_FETCH;
        else if (bus.mem_ready) state_d = ST_MEMWB;
      end
      ST_MEMWR:    if (timeout || bus.mem_ready) state_d = ST_FETCH;
      ST_EXECUTE:  state_d = ST_ALUWB;
      ST_ADDIEXEC: state_d = ST_ADDIWB;
      default:     state_d = ST_FETCH;
    endcase

    stall_cnt_d = (waiting && !timeout && (state_d == state_q)) ? stall_cnt_q + 8'd1 : 8'd0;
  end

  always_comb begin
    pcwrite     = 1'b0;
    branch      = 1'b0;
    branch_cond = 1'b0;
    irwrite     = 1'b0;
    regwrite    = 1'b0;
    memwrite    = 1'b0;
    iord        = 1'b0;
    alusrca     = 1'b0;
    regdst      = 1'b0;
    memtoreg    = 1'b0;
    alusrcb     = 2'b00;
    pcsrc       = 2'b00;
    aluop       = ALUOP_ADD;
    case (state_q)
      ST_FETCH: begin
        alusrcb = 2'b01;
        irwrite = bus.mem_ready && !illegal_q;
        pcwrite = bus.mem_ready && !illegal_q;
      end
      ST_DECODE:   alusrcb = 2'b11;
      ST_MEMADR: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
      end
      ST_MEMRD:    iord = 1'b1;
      ST_MEMWB: begin
        memtoreg = 1'b1;
        regwrite = 1'b1;
      end
      ST_MEMWR: begin
        iord     = 1'b1;
        memwrite = !timeout;
      end
      ST_EXECUTE: begin
        alusrca = 1'b1;
        aluop   = ALUOP_FUNCT;
      end
      ST_ALUWB: begin
        regdst   = 1'b1;
        regwrite = 1'b1;
      end
      ST_BRANCH, ST_BNE: begin
        alusrca     = 1'b1;
        aluop       = ALUOP_SUB;
        branch      = 1'b1;
        pcsrc       = 2'b01;
        branch_cond = (state_q == ST_BNE) ? !bus.zero : bus.zero;
      end
      ST_ADDIEXEC: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
      end
      ST_ADDIWB:   regwrite = 1'b1;
      ST_JUMP: begin
        pcsrc   = 2'b10;
        pcwrite = 1'b1;
      end
      default: ;
    endcase
  end

  mc_aludec u_aludec (
    .aluop      (aluop),
    .funct      (bus.funct),
    .alucontrol (aluc3)
  );

  always_comb begin
    bus.alucontrol      = '0;
    bus.alucontrol[2:0] = aluc3;
  end

  // Gating by the raw reset input makes enables drop without waiting for a clock.
  assign bus.pcen        = reset & (pcwrite | (branch & branch_cond));
  assign bus.irwrite     = reset & irwrite;
  assign bus.regwrite    = reset & regwrite;
  assign bus.memwrite    = reset & memwrite;
  assign bus.iord        = reset & iord;
  assign bus.alusrca     = reset & alusrca;
  assign bus.regdst      = reset & regdst;
  assign bus.memtoreg    = reset & memtoreg;
  assign bus.alusrcb     = reset ? alusrcb : 2'b00;
  assign bus.pcsrc       = reset ? pcsrc : 2'b00;
  assign bus.illegal_op  = reset & illegal_q;
  assign bus.mem_timeout = reset & timeout;
  assign bus.state_dbg   = state_q;

endmodule

`default_nettype wire

// File: tb/tb_mips_multicycle_ctrl.sv
// ============================================================================
// tb_mips_multicycle_ctrl : directed scoreboard bench (STALL_MAX=3, ALUCTRL_W=4)
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_mips_multicycle_ctrl;

  typedef struct packed {
    logic [3:0] st;
    logic       pcen, irwrite, regwrite, memwrite, iord, alusrca, regdst, memtoreg;
    logic [1:0] alusrcb, pcsrc;
    logic [3:0] aluc;
    logic       illegal, tmo;
  } obs_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   total = 0;
  int   pass_cnt = 0;
  int   fail_cnt = 0;
  obs_t exp_q[$];
  string tag_q[$];

  mips_multicycle_ctrl_if #(.ALUCTRL_W(4)) bus ();

  mips_multicycle_ctrl #(.ALUCTRL_W(4), .STALL_MAX(3)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish, expected finish before 200000");
    $fatal(1, "timeout");
  end

  function automatic obs_t sample();
    obs_t o;
    o = '{st: bus.state_dbg, pcen: bus.pcen, irwrite: bus.irwrite, regwrite: bus.regwrite,
          memwrite: bus.memwrite, iord: bus.iord, alusrca: bus.alusrca, regdst: bus.regdst,
          memtoreg: bus.memtoreg, alusrcb: bus.alusrcb, pcsrc: bus.pcsrc,
          aluc: bus.alucontrol, illegal: bus.illegal_op, tmo: bus.mem_timeout};
    return o;
  endfunction

  // Reference table of Moore outputs per state
  function automatic obs_t m(input logic [3:0] st, input logic mr, input logic z,
                             input logic [5:0] fn);
    obs_t o;
    o      = '0;
    o.st   = st;
    o.aluc = 4'b0010;
    case (st)
      4'd0:  begin o.alusrcb = 2'b01; o.irwrite = mr; o.pcen = mr; end
      4'd1:  o.alusrcb = 2'b11;
      4'd2:  begin o.alusrca = 1'b1; o.alusrcb = 2'b10; end
      4'd3:  o.iord = 1'b1;
      4'd4:  begin o.memtoreg = 1'b1; o.regwrite = 1'b1; end
      4'd5:  begin o.iord = 1'b1; o.memwrite = 1'b1; end
      4'd6: begin
        o.alusrca = 1'b1;
        case (fn)
          6'b100010: o.aluc = 4'b0110;
          6'b100100: o.aluc = 4'b0000;
          6'b100101: o.aluc = 4'b0001;
          6'b101010: o.aluc = 4'b0111;
          default:   o.aluc = 4'b0010;
        endcase
      end
      4'd7:  begin o.regdst = 1'b1; o.regwrite = 1'b1; end
      4'd8:  begin o.alusrca = 1'b1; o.aluc = 4'b0110; o.pcsrc = 2'b01; o.pcen = z; end
      4'd9:  begin o.alusrca = 1'b1; o.alusrcb = 2'b10; end
      4'd10: o.regwrite = 1'b1;
      4'd11: begin o.pcsrc = 2'b10; o.pcen = 1'b1; end
      4'd12: begin o.alusrca = 1'b1; o.aluc = 4'b0110; o.pcsrc = 2'b01; o.pcen = ~z; end
      default: ;
    endcase
    return o;
  endfunction

  task automatic set(input logic [5:0] op, input logic [5:0] fn, input logic mr, input logic z);
    bus.op        = op;
    bus.funct     = fn;
    bus.mem_ready = mr;
    bus.zero      = z;
  endtask

  task automatic check(input string tag, input obs_t got, input obs_t e);
    total++;
    assert (got === e) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed %h expected %h", tag, got, e);
    end
  endtask

  // One clock: push expectation, compare at the falling edge, return at posedge+1
  task automatic cyc(input string tag, input obs_t e);
    obs_t  want;
    string t;
    exp_q.push_back(e);
    tag_q.push_back(tag);
    @(negedge clk);
    want = exp_q.pop_front();
    t    = tag_q.pop_front();
    check(t, sample(), want);
    @(posedge clk);
    #1;
  endtask

  obs_t e;
  obs_t rst_exp;
  logic [5:0] fns[6] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010, 6'b111111};

  initial begin
    rst_exp      = '0;
    rst_exp.aluc = 4'b0010;
    set(6'b000000, 6'b100000, 1'b1, 1'b0);
    @(posedge clk);
    #1;
    cyc("reset_0", rst_exp);
    cyc("reset_1", rst_exp);
    reset = 1'b1;

    // R-type across the funct table
    foreach (fns[i]) begin
      set(6'b000000, fns[i], 1'b1, 1'b0);
      cyc("r_fetch",  m(4'd0, 1'b1, 1'b0, fns[i]));
      cyc("r_decode", m(4'd1, 1'b1, 1'b0, fns[i]));
      cyc("r_exec",   m(4'd6, 1'b1, 1'b0, fns[i]));
      cyc("r_wb",     m(4'd7, 1'b1, 1'b0, fns[i]));
    end

    // lw with two wait cycles in MEMRD
    set(6'b100011, 6'b0, 1'b1, 1'b0);
    cyc("lw_fetch",  m(4'd0, 1'b1, 1'b0, 6'b0));
    cyc("lw_decode", m(4'd1, 1'b1, 1'b0, 6'b0));
    cyc("lw_memadr", m(4'd2, 1'b1, 1'b0, 6'b0));
    set(6'b100011, 6'b0, 1'b0, 1'b0);
    cyc("lw_memrd_w0", m(4'd3, 1'b0, 1'b0, 6'b0));
    cyc("lw_memrd_w1", m(4'd3, 1'b0, 1'b0, 6'b0));
    set(6'b100011, 6'b0, 1'b1, 1'b0);
    cyc("lw_memrd_rdy", m(4'd3, 1'b1, 1'b0, 6'b0));
    cyc("lw_memwb",     m(4'd4, 1'b1, 1'b0, 6'b0));

    // beq taken then not taken
    for (int z = 1; z >= 0; z--) begin
      set(6'b000100, 6'b0, 1'b1, 1'(z));
      cyc("beq_fetch",  m(4'd0, 1'b1, 1'(z), 6'b0));
      cyc("beq_decode", m(4'd1, 1'b1, 1'(z), 6'b0));
      cyc("beq_branch", m(4'd8, 1'b1, 1'(z), 6'b0));
    end

    // addi then jump
    set(6'b001000, 6'b0, 1'b1, 1'b0);
    cyc("addi_fetch",  m(4'd0, 1'b1, 1'b0, 6'b0));
    cyc("addi_decode", m(4'd1, 1'b1, 1'b0, 6'b0));
    cyc("addi_exec",   m(4'd9, 1'b1, 1'b0, 6'b0));
    cyc("addi_wb",     m(4'd10, 1'b1, 1'b0, 6'b0));
    set(6'b000010, 6'b0, 1'b1, 1'b0);
    cyc("j_fetch",  m(4'd0, 1'b1, 1'b0, 6'b0));
    cyc("j_decode", m(4'd1, 1'b1, 1'b0, 6'b0));
    cyc("j_jump",   m(4'd11, 1'b1, 1'b0, 6'b0));

    // FETCH timeout on the third wait cycle, counter restarts afterwards
    set(6'b000010, 6'b0, 1'b0, 1'b0);
    cyc("fto_w1", m(4'd0, 1'b0, 1'b0, 6'b0));
    cyc("fto_w2", m(4'd0, 1'b0, 1'b0, 6'b0));
    e     = m(4'd0, 1'b0, 1'b0, 6'b0);
    e.tmo = 1'b1;
    cyc("fto_w3", e);
    cyc("fto_after", m(4'd0, 1'b0, 1'b0, 6'b0));

    // sw timing out in MEMWR: memwrite withdrawn on the timeout cycle
    set(6'b101011, 6'b0, 1'b1, 1'b0);
    cyc("sw_fetch",  m(4'd0, 1'b1, 1'b0, 6'b0));
    cyc("sw_decode", m(4'd1, 1'b1, 1'b0, 6'b0));
    cyc("sw_memadr", m(4'd2, 1'b1, 1'b0, 6'b0));
    set(6'b101011, 6'b0, 1'b0, 1'b0);
    cyc("sw_memwr_w1", m(4'd5, 1'b0, 1'b0, 6'b0));
    cyc("sw_memwr_w2", m(4'd5, 1'b0, 1'b0, 6'b0));
    e          = m(4'd5, 1'b0, 1'b0, 6'b0);
    e.memwrite = 1'b0;
    e.tmo      = 1'b1;
    cyc("sw_memwr_tmo", e);

    // op 000101: BNE when enabled, illegal otherwise
    set(6'b000101, 6'b0, 1'b1, 1'b0);
    cyc("bne_fetch",  m(4'd0, 1'b1, 1'b0, 6'b0));
    cyc("bne_decode", m(4'd1, 1'b1, 1'b0, 6'b0));
`ifdef MC_BNE_EN
    cyc("bne_state", m(4'd12, 1'b1, 1'b0, 6'b0));
`else
    e         = m(4'd0, 1'b1, 1'b0, 6'b0);
    e.irwrite = 1'b0;
    e.pcen    = 1'b0;
    e.illegal = 1'b1;
    cyc("illegal_pulse", e);
`endif
    set(6'b000010, 6'b0, 1'b1, 1'b0);
    cyc("post_op5_fetch",  m(4'd0, 1'b1, 1'b0, 6'b0));
    cyc("post_op5_decode", m(4'd1, 1'b1, 1'b0, 6'b0));
    cyc("post_op5_jump",   m(4'd11, 1'b1, 1'b0, 6'b0));

    // Unknown opcode is always illegal
    set(6'b111111, 6'b0, 1'b1, 1'b0);
    cyc("ill_fetch",  m(4'd0, 1'b1, 1'b0, 6'b0));
    cyc("ill_decode", m(4'd1, 1'b1, 1'b0, 6'b0));
    e         = m(4'd0, 1'b1, 1'b0, 6'b0);
    e.irwrite = 1'b0;
    e.pcen    = 1'b0;
    e.illegal = 1'b1;
    cyc("ill_pulse", e);

    // Reset asserted mid-MEMWR drops memwrite without a clock
    set(6'b101011, 6'b0, 1'b1, 1'b0);
    cyc("rst_sw_fetch",  m(4'd0, 1'b1, 1'b0, 6'b0));
    cyc("rst_sw_decode", m(4'd1, 1'b1, 1'b0, 6'b0));
    cyc("rst_sw_memadr", m(4'd2, 1'b1, 1'b0, 6'b0));
    set(6'b101011, 6'b0, 1'b0, 1'b0);
    @(negedge clk);
    check("rst_sw_memwr", sample(), m(4'd5, 1'b0, 1'b0, 6'b0));
    #2;
    reset = 1'b0;
    #1;
    check("rst_async", sample(), rst_exp);
    @(posedge clk);
    #1;
    reset = 1'b1;
    set(6'b000000, 6'b100010, 1'b1, 1'b0);
    cyc("rst_release_fetch", m(4'd0, 1'b1, 1'b0, 6'b100010));
    cyc("rst_release_decode", m(4'd1, 1'b1, 1'b0, 6'b100010));

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/mips_multicycle_ctrl.md
Name: mips_multicycle_ctrl

Overview:
- Parametrised multicycle successor to the single-cycle MIPS control unit.
- Moore FSM sequences FETCH/DECODE/execute/writeback over several cycles, driving datapath enables and muxes.
- Adds a memory-ready handshake with a bounded stall counter and illegal-opcode detection.
- Contains the ALU decoder.

Parameters:
- ALUCTRL_W, 3: alucontrol width. Must be ≥3; bits above [2:0] are driven 0.
- STALL_MAX, 15: maximum consecutive wait cycles on mem_ready before a timeout (1..255).

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low (0 = reset)
- op  in  6  instruction[31:26]
- funct  in  6  instruction[5:0]
- zero  in  1  ALU zero flag
- mem_ready  in  1  memory access completes this cycle
- pcen  out  1  PC write enable = pcwrite | (branch & branch_cond)
- irwrite, regwrite, memwrite  out  1  each  datapath write enables
- iord, alusrca, regdst, memtoreg  out  1  each  mux selects
- alusrcb  out  2  00 reg B, 01 const 4, 10 signimm, 11 signimm<<2
- pcsrc  out  2  00 ALU result, 01 ALUOut, 10 jump target
- alucontrol  out  ALUCTRL_W  ALU operation
- illegal_op, mem_timeout  out  1  each  single-cycle pulses
- state_dbg  out  4  current state encoding

Behaviour:
- Reset:
  - State goes to FETCH asynchronously. Stall counter = 0.
  - While reset=0, pcen, irwrite, regwrite, memwrite, illegal_op and mem_timeout are forced to 0. All mux selects are 0. state_dbg = 0.
- Outputs are decoded from the state register. Only pcen depends combinationally on zero.
- States and their outputs (unlisted outputs are 0):
  - FETCH: alusrcb=01, aluop=00. irwrite=pcwrite=mem_ready. Stay until mem_ready, then go to DECODE.
  - DECODE: alusrcb=11. Next state by op:
    - 100011 or 101011 → MEMADR
    - 000000 → EXECUTE
    - 000100 → BRANCH
    - 001000 → ADDIEXEC
    - 000010 → JUMP
    - anything else → FETCH, with illegal_op pulsed for one cycle and no writes.
  - MEMADR: alusrca=1, alusrcb=10. Next is MEMRD for lw, MEMWR for sw.
  - MEMRD: iord=1. Wait for mem_ready, then go to MEMWB.
  - MEMWB: memtoreg=1, regwrite=1 → FETCH.
  - MEMWR: iord=1, memwrite=1, held until mem_ready → FETCH.
  - EXECUTE: alusrca=1, aluop=10 → ALUWB.
  - ALUWB: regdst=1, regwrite=1 → FETCH.
  - BRANCH: alusrca=1, aluop=01, branch=1, pcsrc=01, branch_cond=zero → FETCH.
  - ADDIEXEC: alusrca=1, alusrcb=10 → ADDIWB.
  - ADDIWB: regwrite=1 → FETCH.
  - JUMP: pcsrc=10, pcwrite=1 → FETCH.
- ALU decode:
  - aluop=00 → 010 (add). aluop=01 → 110 (sub).
  - aluop=10 by funct: 100000→010, 100010→110, 100100→000, 100101→001, 101010→111. Any other funct → 010.
- Stall counter:
  - Increments each cycle spent in FETCH, MEMRD or MEMWR with mem_ready=0. Clears on mem_ready or on a state change.
  - When the count reaches STALL_MAX with mem_ready still 0: pulse mem_timeout, go to FETCH, and assert no write enables that cycle.
  - mem_ready in the same cycle as the limit counts as completion; no timeout.
- Reset asserted mid-MEMWR: memwrite drops immediately (asynchronously).

Optional Feature:
- Macro MC_BNE_EN.
- Defined: op 000101 in DECODE → state BNE (encoding 12), with the same outputs as BRANCH but branch_cond=~zero.
- Undefined: 000101 is illegal and pulses illegal_op.

Decomposition:
- Package mips_mc_pkg holds:
  - the state enum with fixed encodings: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXECUTE=6, ALUWB=7, BRANCH=8, ADDIEXEC=9, ADDIWB=10, JUMP=11, BNE=12;
  - opcode and funct constants;
  - ALUOP_* constants.
- One sub-module, mc_aludec: purely combinational (aluop, funct → alucontrol).

Test Plan:
- add R-type (op=0, funct=100000), mem_ready=1: state_dbg sequence 0,1,6,7,0. alucontrol=010 in EXECUTE. regwrite=1 and regdst=1 only in ALUWB.
- lw with mem_ready=0 for 2 cycles in MEMRD: state_dbg 0,1,2,3,3,3,4,0. memtoreg=1 in MEMWB. mem_timeout never asserts.
- beq: zero=1 gives pcen=1 in BRANCH with pcsrc=01. zero=0 gives pcen=0. Next state FETCH in both cases.
- STALL_MAX=3, mem_ready held 0 in FETCH: mem_timeout pulses once on the 3rd wait cycle. State returns to FETCH. irwrite and pcen stay 0 throughout.
- op=000101 with MC_BNE_EN undefined: illegal_op=1 for 1 cycle after DECODE, no enables asserted. With MC_BNE_EN defined and zero=0: state 12, pcen=1.
- reset driven low mid-MEMWR with memwrite=1: memwrite=0 before the next clk edge. After release, state_dbg=0.
